rle_dec: RTL and testbench

- Run-length decoder; sits directly downstream of the RLE encoder in the lab3 datapath.
- Pops 24-bit run words (bit value + run length) from the encoder's output FIFO.
- Expands each run back into a serial bit stream and packs the bits MSB-first into bytes.
- Pushes the bytes into an output byte FIFO, which closes the encode/decode loopback for checking.

---
 rtl/rle_dec.sv | 138 +++++++++++++
 tb/tb_rle_dec.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_dec.sv
// Run-length decoder: pops {bit, run} words, expands runs MSB-first into bytes, flushes a padded tail.
// Optional macro RLE_DEC_FAST_FILL_EN: expand up to a whole byte's worth of bits per cycle.
module rle_dec #(
  parameter int RUN_W = 23,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             recv_ready,
  input  logic [RUN_W:0]   in_data,
  input  logic             end_of_stream,
  output logic             rd_req,
  input  logic             send_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             wr_req,
  output logic             done
);

  localparam int FILL_W = $clog2(OUT_W + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(OUT_W);

  typedef enum logic [2:0] {IDLE, READ, LOAD, EXPAND, WRITE, FLUSH, DONE} state_t;

  state_t             state, state_n;
  logic               bit_val, bit_val_n;
  logic [RUN_W-1:0]   run, run_n;
  logic [FILL_W-1:0]  fill, fill_n;
  logic [OUT_W-1:0]   sr, sr_n;
  logic [OUT_W-1:0]   out_n;
  logic               flushing, flushing_n;

  // Expansion datapath: step bits of bit_val shifted into sr this cycle.
  logic [FILL_W-1:0]  step;
  logic [2*OUT_W-1:0] shifted;
  logic [OUT_W-1:0]   ones;
  logic [OUT_W-1:0]   ex_sr;
  logic [FILL_W-1:0]  ex_fill;
  logic [RUN_W-1:0]   ex_run;
  logic [OUT_W-1:0]   pad;

  always_comb begin
`ifdef RLE_DEC_FAST_FILL_EN
    step = (run < RUN_W'(FULL - fill)) ? FILL_W'(run) : (FULL - fill);
`else
    step = FILL_W'(1);
`endif
    shifted = {{OUT_W{1'b0}}, sr} << step;
    ones    = {OUT_W{1'b1}} >> (FULL - step);
    ex_sr   = shifted[OUT_W-1:0] | (bit_val ? ones : {OUT_W{1'b0}});
    ex_fill = fill + step;
    ex_run  = run - RUN_W'(step);
    pad     = sr << (FULL - fill);
  end

  // NOTE: every output and next-state value gets a default first so no path leaves a latch.
  always_comb begin
    state_n    = state;
    bit_val_n  = bit_val;
    run_n      = run;
    fill_n     = fill;
    sr_n       = sr;
    out_n      = out_data;
    flushing_n = flushing;
    rd_req     = 1'b0;
    wr_req     = 1'b0;
    done       = 1'b0;

    unique case (state)
      IDLE: begin
        if (recv_ready)         state_n = READ;
        else if (end_of_stream) state_n = FLUSH;
      end
      READ: begin
        rd_req  = 1'b1;
        state_n = LOAD;
      end
      LOAD: begin
        bit_val_n = in_data[RUN_W];
        run_n     = in_data[RUN_W-1:0];
        state_n   = (in_data[RUN_W-1:0] == '0) ? IDLE : EXPAND;
      end
      EXPAND: begin
        sr_n   = ex_sr;
        fill_n = ex_fill;
        run_n  = ex_run;
        if (ex_fill == FULL) begin
          out_n   = ex_sr;
          state_n = WRITE;
        end else if (ex_run == '0) begin
          state_n = IDLE;
        end
      end
      WRITE: begin
        // Push is gated directly by the FIFO's not-full flag so a stall costs no extra cycle.
        if (send_ready) begin
          wr_req = 1'b1;
          fill_n = '0;
          if (run != '0)    state_n = EXPAND;
          else if (flushing) state_n = DONE;
          else               state_n = IDLE;
        end
      end
      FLUSH: begin
        if (fill == '0) begin
          state_n = DONE;
        end else begin
          out_n      = pad;
          flushing_n = 1'b1;
          state_n    = WRITE;
        end
      end
      DONE: done = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_val  <= 1'b0;
      run      <= '0;
      fill     <= '0;
      sr       <= '0;
      out_data <= '0;
      flushing <= 1'b0;
    end else begin
      state    <= state_n;
      bit_val  <= bit_val_n;
      run      <= run_n;
      fill     <= fill_n;
      sr       <= sr_n;
      out_data <= out_n;
      flushing <= flushing_n;
    end
  end

endmodule

// File: tb/tb_rle_dec.sv
// Directed and random self-checking bench for rle_dec with a 1-cycle-latency input FIFO model.
module tb_rle_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic        recv_ready;
  logic [23:0] in_data;
  logic        end_of_stream;
  logic        rd_req;
  logic        send_ready;
  logic [7:0]  out_data;
  logic        wr_req;
  logic        done;

  rle_dec dut (
    .clk(clk), .rst(rst), .recv_ready(recv_ready), .in_data(in_data),
    .end_of_stream(end_of_stream), .rd_req(rd_req), .send_ready(send_ready),
    .out_data(out_data), .wr_req(wr_req), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] inq[$];
  logic [23:0] stim_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          max_pulse;
  int          overlap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor samples outputs at negedge; FIFO model updates 1 time unit after posedge.
  initial begin
    int  cur;
    logic pop;
    cur = 0;
    forever begin
      @(negedge clk);
      pop = rd_req;
      if (wr_req) begin
        got_q.push_back(out_data);
        cur++;
      end else begin
        cur = 0;
      end
      if (cur > max_pulse) max_pulse = cur;
      if (rd_req && wr_req) overlap++;
      @(posedge clk);
      #1;
      if (pop && inq.size() != 0) in_data = inq.pop_front();
      recv_ready = (inq.size() != 0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inq.delete();
    recv_ready    = 1'b0;
    end_of_stream = 1'b0;
    send_ready    = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic push_stim();
    foreach (stim_q[i]) inq.push_back(stim_q[i]);
    recv_ready = (inq.size() != 0);
  endtask

  // Feeds stim_q, raises end_of_stream, waits for done and compares bytes with exp_q.
  task automatic run_case(input string name, input int limit, output int cycles);
    int n;
    got_q.delete();
    max_pulse = 0;
    overlap   = 0;
    push_stim();
    cyc();
    end_of_stream = 1'b1;
    cycles = 1;
    while (!done && cycles < limit) begin
      cyc();
      cycles++;
    end
    check({name, "_done"}, done, 1);
    check({name, "_nbytes"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
    n = got_q.size();
    repeat (3) cyc();
    check({name, "_done_held"}, done, 1);
    check({name, "_quiet_after_done"}, got_q.size(), n);
    check({name, "_no_overlap"}, overlap, 0);
  endtask

  task automatic build_expected();
    logic [7:0] acc;
    int nb;
    acc = '0;
    nb  = 0;
    exp_q.delete();
    foreach (stim_q[i]) begin
      for (int j = 0; j < int'(stim_q[i][22:0]); j++) begin
        acc = {acc[6:0], stim_q[i][23]};
        nb++;
        if (nb == 8) begin
          exp_q.push_back(acc);
          nb = 0;
        end
      end
    end
    if (nb > 0) exp_q.push_back(acc << (8 - nb));
  endtask

  initial begin
    int cycles;
    int waited;
    int total_bits;
    logic found;

    rst = 1'b1; recv_ready = 1'b0; in_data = '0; end_of_stream = 1'b0; send_ready = 1'b1;
    max_pulse = 0; overlap = 0;
    cyc(); cyc();
    check("rst_rd_req", rd_req, 0);
    check("rst_wr_req", wr_req, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_done", done, 0);
    rst = 1'b0;

    // 32 zeros: four 00 bytes, no flush write
    do_reset();
    stim_q = '{{1'b0, 23'd32}};
    exp_q  = '{8'h00, 8'h00, 8'h00, 8'h00};
    run_case("zeros32", 500, cycles);

    // alternating single-bit runs: AA
    do_reset();
    stim_q.delete();
    repeat (4) begin
      stim_q.push_back({1'b1, 23'd1});
      stim_q.push_back({1'b0, 23'd1});
    end
    exp_q = '{8'hAA};
    run_case("alt", 500, cycles);

    // zero-length word discarded, then 111 padded to E0
    do_reset();
    stim_q = '{{1'b1, 23'd0}, {1'b1, 23'd3}};
    exp_q  = '{8'hE0};
    run_case("flush", 500, cycles);

    // back-pressure at first WRITE
    do_reset();
    send_ready = 1'b0;
    got_q.delete();
    max_pulse = 0;
    stim_q = '{{1'b1, 23'd16}};
    push_stim();
    found  = 1'b0;
    waited = 0;
    while (!found && waited < 40) begin
      cyc();
      waited++;
      found = (out_data == 8'hFF);
    end
    check("stall_reached_write", found, 1);
    found = 1'b1;
    repeat (10) begin
      if (wr_req !== 1'b0 || out_data !== 8'hFF) found = 1'b0;
      cyc();
    end
    check("stall_held", found, 1);
    check("stall_no_write", got_q.size(), 0);
    send_ready = 1'b1;
    stim_q.delete();
    exp_q = '{8'hFF, 8'hFF};
    run_case("stall", 500, cycles);
    check("stall_pulse_len", max_pulse, 1);

    // reset with a partial byte of fill 5
    do_reset();
`ifdef RLE_DEC_FAST_FILL_EN
    stim_q = '{{1'b1, 23'd5}, {1'b1, 23'd20}};
`else
    stim_q = '{{1'b1, 23'd20}};
`endif
    push_stim();
    waited = 0;
    while (dut.fill != 4'd5 && waited < 60) begin
      cyc();
      waited++;
    end
    check("midrst_fill5_reached", (dut.fill == 4'd5), 1);
    rst = 1'b1;
    inq.delete();
    recv_ready = 1'b0;
    cyc();
    rst = 1'b0;
    check("midrst_rd_req", rd_req, 0);
    check("midrst_wr_req", wr_req, 0);
    check("midrst_out_data", out_data, 8'h00);
    check("midrst_done", done, 0);
    stim_q = '{{1'b0, 23'd8}};
    exp_q  = '{8'h00};
    run_case("post_rst", 500, cycles);

    // random stream against the bit-level model
    do_reset();
    stim_q.delete();
    total_bits = 0;
    for (int i = 0; i < 200; i++) begin
      logic [22:0] r;
      logic        b;
      r = 23'($urandom_range(40, 1));
      b = 1'($urandom_range(1, 0));
      stim_q.push_back({b, r});
      total_bits += int'(r);
    end
    build_expected();
    run_case("rand", 30000, cycles);
`ifdef RLE_DEC_FAST_FILL_EN
    check("rand_fast_cycles_below_bits", (cycles < total_bits), 1);
`else
    check("rand_base_cycles_at_least_bits", (cycles >= total_bits), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
